rram_op_scheduler: RTL and testbench

- Sequences the RRAM address/state counter (`state_counter`) across three operation types:
  - forming sweep;
  - cache-to-RRAM write-back;
  - RRAM-to-cache read.
- Latches request pulses from the host-side control, arbitrates between them and drives the counter's `en`/`forming`/`we`/`re` controls.
- Detects completion through the counter's count flags.
- Sits between the top-level command decoder and `state_counter`. Enforces "no write/read before forming".

---
 rtl/rram_op_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_rram_op_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_op_scheduler.sv
// rtl/rram_op_scheduler.sv - forming/write-back/read sequencer for the RRAM state counter
//
// Latches host request pulses, arbitrates between them and drives the
// state_counter mode strobes until the active sweep reports completion
// or the per-operation timeout expires. Writes and reads are held off
// until the array has been formed at least once.
//
// Optional build macro: RR_ARB_EN
//   defined   - write and read alternate when both are pending (read first after reset)
//   undefined - fixed priority form > write > read
//
// Parameters:
//   TIMEOUT  cycles an operation may run without its completion flag
//   TO_W     timeout counter width, 2**TO_W > TIMEOUT
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_form/write/read      one-cycle request pulses from the command decoder
//   forming_count_flag       forming sweep complete
//   write_count_flag         write sweep complete
//   cache_count_flag         read-to-cache sweep complete
//   cnt_en, cnt_forming,
//   cnt_we, cnt_re           registered counter controls
//   busy                     high in every state except IDLE
//   formed                   sticky, array has completed forming
//   done, done_op, err       end-of-operation pulse, op code (01/10/11), timeout flag
//   pend                     pending request bits {read, write, form}
module rram_op_scheduler #(
    parameter int TIMEOUT = 100,
    parameter int TO_W    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_form,
    input  logic       req_write,
    input  logic       req_read,
    input  logic       forming_count_flag,
    input  logic       write_count_flag,
    input  logic       cache_count_flag,
    output logic       cnt_en,
    output logic       cnt_forming,
    output logic       cnt_we,
    output logic       cnt_re,
    output logic       busy,
    output logic       formed,
    output logic       done,
    output logic [1:0] done_op,
    output logic       err,
    output logic [2:0] pend
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FORM  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      grant;
    logic            flag_hit;
    logic            to_last;
    logic [1:0]      op_code;

`ifdef RR_ARB_EN
    // 1 = read was granted last; reset value 0 lets read win the first tie
    logic            last_rd;
`endif

    // Arbitration only happens in IDLE on the registered pending bits, so a
    // request needs one edge to land in pend and a second edge to be granted.
    always_comb begin
        grant = 3'b000;
        if (state == S_IDLE) begin
            if (pend[0]) begin
                grant = 3'b001;
            end
`ifdef RR_ARB_EN
            else if (formed && pend[1] && pend[2]) begin
                grant = last_rd ? 3'b010 : 3'b100;
            end
`endif
            else if (formed && pend[1]) begin
                grant = 3'b010;
            end else if (formed && pend[2]) begin
                grant = 3'b100;
            end
        end
    end

    // Only the active operation's completion flag is observed.
    always_comb begin
        flag_hit = 1'b0;
        op_code  = 2'b00;
        case (state)
            S_FORM: begin
                flag_hit = forming_count_flag;
                op_code  = 2'b01;
            end
            S_WRITE: begin
                flag_hit = write_count_flag;
                op_code  = 2'b10;
            end
            S_READ: begin
                flag_hit = cache_count_flag;
                op_code  = 2'b11;
            end
            default: begin
                flag_hit = 1'b0;
                op_code  = 2'b00;
            end
        endcase
    end

    assign to_last = (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend        <= 3'b000;
            formed      <= 1'b0;
            to_cnt      <= '0;
            cnt_en      <= 1'b0;
            cnt_forming <= 1'b0;
            cnt_we      <= 1'b0;
            cnt_re      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_op     <= 2'b00;
            err         <= 1'b0;
`ifdef RR_ARB_EN
            last_rd     <= 1'b0;
`endif
        end else begin
            // A request coinciding with its own grant re-arms the bit.
            pend    <= (pend & ~grant) | {req_read, req_write, req_form};
            done    <= 1'b0;
            done_op <= 2'b00;
            err     <= 1'b0;

            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (grant != 3'b000) begin
                        busy   <= 1'b1;
                        cnt_en <= 1'b1;
                    end
                    if (grant[0]) begin
                        state       <= S_FORM;
                        cnt_forming <= 1'b1;
                    end else if (grant[1]) begin
                        state  <= S_WRITE;
                        cnt_we <= 1'b1;
`ifdef RR_ARB_EN
                        last_rd <= 1'b0;
`endif
                    end else if (grant[2]) begin
                        state  <= S_READ;
                        cnt_re <= 1'b1;
`ifdef RR_ARB_EN
                        last_rd <= 1'b1;
`endif
                    end
                end

                S_FORM, S_WRITE, S_READ: begin
                    // A flag on the final timeout cycle still counts as success.
                    if (flag_hit || to_last) begin
                        state       <= S_DONE;
                        cnt_en      <= 1'b0;
                        cnt_forming <= 1'b0;
                        cnt_we      <= 1'b0;
                        cnt_re      <= 1'b0;
                        done        <= 1'b1;
                        done_op     <= op_code;
                        err         <= ~flag_hit;
                        if (state == S_FORM && flag_hit) begin
                            formed <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state       <= S_IDLE;
                    cnt_en      <= 1'b0;
                    cnt_forming <= 1'b0;
                    cnt_we      <= 1'b0;
                    cnt_re      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rram_op_scheduler.sv
// tb/tb_rram_op_scheduler.sv - scoreboard bench for rram_op_scheduler
module tb_rram_op_scheduler;

    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_form = 1'b0;
    logic       req_write = 1'b0;
    logic       req_read = 1'b0;
    logic       forming_count_flag = 1'b0;
    logic       write_count_flag = 1'b0;
    logic       cache_count_flag = 1'b0;
    logic       cnt_en, cnt_forming, cnt_we, cnt_re;
    logic       busy, formed, done, err;
    logic [1:0] done_op;
    logic [2:0] pend;

    rram_op_scheduler #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_form(req_form), .req_write(req_write), .req_read(req_read),
        .forming_count_flag(forming_count_flag),
        .write_count_flag(write_count_flag),
        .cache_count_flag(cache_count_flag),
        .cnt_en(cnt_en), .cnt_forming(cnt_forming), .cnt_we(cnt_we), .cnt_re(cnt_re),
        .busy(busy), .formed(formed), .done(done), .done_op(done_op),
        .err(err), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic       err;
        int         dur;
        logic       formed;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         len_op[3];
    logic       formed_m = 1'b0;
    logic [2:0] pend_m = 3'b000;
    logic       last_rd_m = 1'b0;
    int         ocnt = 0;
    int         dur = 0;
    int         idle_run = 2;
    bit         expect_b2b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run every operation the pending set allows, in the
    // order the priority rules dictate, each lasting its sweep length or the
    // timeout, whichever is shorter.
    function automatic void model_run(input logic [2:0] newbits);
        int   op;
        exp_t e;
        pend_m |= newbits;
        for (int g = 0; g < 4; g++) begin
            op = -1;
            if (pend_m[0]) op = 0;
            else if (formed_m && pend_m[1] && pend_m[2]) begin
`ifdef RR_ARB_EN
                op = last_rd_m ? 1 : 2;
`else
                op = 1;
`endif
            end
            else if (formed_m && pend_m[1]) op = 1;
            else if (formed_m && pend_m[2]) op = 2;
            if (op < 0) break;
            pend_m[op] = 1'b0;
            e.op  = 2'(op + 1);
            e.err = (len_op[op] > TIMEOUT);
            e.dur = e.err ? TIMEOUT : len_op[op];
            if (op == 0 && !e.err) formed_m = 1'b1;
            e.formed = formed_m;
            if (op == 1) last_rd_m = 1'b0;
            if (op == 2) last_rd_m = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    function automatic int pick_len();
        case ($urandom_range(0, 9))
            0: return 1;
            1: return TIMEOUT - 1;
            2: return TIMEOUT;
            3: return TIMEOUT + 1;
            default: return $urandom_range(2, 40);
        endcase
    endfunction

    // Counter emulator plus monitor. The active sweep raises its flag after
    // len_op cycles of strobe; flags of idle sweeps carry random noise.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] m;
        if (rst) begin
            ocnt = 0;
            dur = 0;
            idle_run = 2;
            expect_b2b = 1'b0;
            forming_count_flag = 1'b0;
            write_count_flag = 1'b0;
            cache_count_flag = 1'b0;
        end else begin
            if (cnt_en) ocnt++;
            else ocnt = 0;
            forming_count_flag = (cnt_en && cnt_forming) ? (ocnt == len_op[0]) : 1'($urandom_range(0, 1));
            write_count_flag   = (cnt_en && cnt_we)      ? (ocnt == len_op[1]) : 1'($urandom_range(0, 1));
            cache_count_flag   = (cnt_en && cnt_re)      ? (ocnt == len_op[2]) : 1'($urandom_range(0, 1));

            m = {cnt_re, cnt_we, cnt_forming};
            chk("strobe_onehot", ($onehot0(m) && (cnt_en == (|m))), 1);
            chk("busy", busy, cnt_en | done);
            if (!done) chk("idle_code", {done_op, err}, 0);

            if (cnt_en) begin
                if (dur == 0 && expect_b2b) begin
                    chk("b2b_gap", idle_run, 2);
                    expect_b2b = 1'b0;
                end
                dur++;
                idle_run = 0;
            end else begin
                idle_run++;
            end

            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done act=op%0d exp=none t=%0t", done_op, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_op", done_op, e.op);
                    chk("done_err", err, e.err);
                    chk("op_cycles", dur, e.dur);
                    chk("formed", formed, e.formed);
                end
                dur = 0;
                expect_b2b = (exp_q.size() != 0);
            end
        end
    end

    task automatic issue(input logic [2:0] bits);
        model_run(bits);
        @(negedge clk);
        {req_read, req_write, req_form} = bits;
        @(negedge clk);
        {req_read, req_write, req_form} = 3'b000;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_time"}, (n < 2000), 1);
        repeat (3) @(negedge clk);
        chk({name, "_pend"}, pend, pend_m);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        len_op[0] = 10;
        len_op[1] = 10;
        len_op[2] = 10;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {cnt_en, cnt_forming, cnt_we, cnt_re, busy, formed, done, done_op, err, pend}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write before forming: held pending, nothing runs.
        len_op[1] = $urandom_range(3, 20);
        issue(3'b010);
        repeat (20) begin
            @(negedge clk);
            chk("unformed_idle", {cnt_en, done}, 0);
        end
        chk("unformed_pend", pend, 3'b010);

        // Forming sweep of 32 cycles, then the held write starts.
        len_op[0] = 32;
        model_run(3'b001);
        @(negedge clk);
        req_form = 1'b1;
        @(posedge clk);
        #1;
        chk("form_pend_set", pend[0], 1);
        chk("form_not_started", cnt_en, 0);
        req_form = 1'b0;
        @(posedge clk);
        #1;
        chk("form_strobes", {cnt_en, cnt_forming, cnt_we, cnt_re}, 4'b1100);
        wait_idle("form_then_write");
        chk("formed_after_form", formed, 1);

        // Simultaneous write and read.
        len_op[1] = $urandom_range(3, 30);
        len_op[2] = $urandom_range(3, 30);
        issue(3'b110);
        wait_idle("write_read_tie");

        // Write that never sees its flag times out.
        len_op[1] = TIMEOUT + 50;
        issue(3'b010);
        wait_idle("write_timeout");

        // Read requested again on its grant edge runs twice.
        len_op[2] = $urandom_range(4, 20);
        model_run(3'b100);
        model_run(3'b100);
        @(negedge clk);
        req_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_read = 1'b0;
        wait_idle("read_rerun");

        // Reset in the 10th cycle of a read.
        len_op[2] = 60;
        issue(3'b100);
        n = 0;
        while (!cnt_re && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("read_started", cnt_re, 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_read", {cnt_en, cnt_forming, cnt_we, cnt_re, busy, formed, done, done_op, err, pend}, 0);
        exp_q.delete();
        formed_m = 1'b0;
        pend_m = 3'b000;
        last_rd_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("after_reset_quiet", {done, cnt_en}, 0);
        end

        // Random batches, starting unformed after the reset.
        for (int i = 0; i < 25; i++) begin
            logic [2:0] bits;
            bits = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) len_op[k] = pick_len();
            issue(bits);
            wait_idle("random_batch");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
